// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: opcode/state enums and command-byte field positions for spi_cmd.
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        WRITE_AT   = 2'b00,
        READ_AT    = 2'b01,
        WRITE_NEXT = 2'b10,
        READ_NEXT  = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        DATA,
        ACCESS
    } state_t;

    localparam int OPCODE_MSB = 7;
    localparam int OPCODE_LSB = 6;
    localparam int A16_BIT    = 0;

endpackage

// File: rtl/spi_cmd_sync.sv
// spi_cmd_sync: multi-flop single-bit synchroniser with asynchronous reset to RST_VAL.
module spi_cmd_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ff <= {STAGES{RST_VAL}};
        else
            ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_cmd.sv
// spi_cmd: decodes SPI command packets (resynchronised from the SCLK domain)
// into held-strobe bus reads/writes and returns read data on spi_tx.
module spi_cmd
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_cs_n,
    input  logic [7:0]            spi_rx,
    input  logic                  spi_valid,
    output logic [7:0]            spi_tx,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wr_data,
    input  logic [7:0]            bus_rd_data,
    output logic                  bus_rd_strobe,
    output logic                  bus_wr_strobe,
    input  logic                  bus_done,
    output logic                  overrun
);

    logic    valid_s, valid_d, cs_s, cs_d;
    logic    byte_strobe, reselect, is_read, a16;
    logic [7:0] hi;
    state_t  state, state_nx;
    opcode_t op, rx_op;

    spi_cmd_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_valid_sync (
        .clk(clk), .reset(reset), .d(spi_valid), .q(valid_s)
    );

    spi_cmd_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .d(spi_cs_n), .q(cs_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_d <= 1'b0;
            cs_d    <= 1'b1;
        end else begin
            valid_d <= valid_s;
            cs_d    <= cs_s;
        end
    end

    // Bytes are only accepted while selected; spi_rx is stable for the whole valid window.
    assign byte_strobe   = valid_s & ~valid_d & ~cs_s;
    assign reselect      = cs_d & ~cs_s;
    assign rx_op         = opcode_t'(spi_rx[OPCODE_MSB:OPCODE_LSB]);
    assign is_read       = (op == READ_AT) || (op == READ_NEXT);
    assign bus_rd_strobe = (state == ACCESS) && is_read;
    assign bus_wr_strobe = (state == ACCESS) && !is_read;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (byte_strobe)
                         state_nx = (rx_op == WRITE_AT || rx_op == READ_AT) ? ADDR_HI :
                                    (rx_op == WRITE_NEXT) ? DATA : ACCESS;
            ADDR_HI: if (byte_strobe) state_nx = ADDR_LO;
            ADDR_LO: if (byte_strobe) state_nx = (op == READ_AT) ? ACCESS : DATA;
            DATA:    if (byte_strobe) state_nx = ACCESS;
            ACCESS:  if (bus_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // An access in flight always completes; anything else is abandoned on deselect.
        if (cs_s && state != ACCESS)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op          <= WRITE_AT;
            a16         <= 1'b0;
            hi          <= 8'h00;
            bus_addr    <= '0;
            bus_wr_data <= 8'h00;
            spi_tx      <= 8'h00;
            overrun     <= 1'b0;
        end else begin
            if (byte_strobe) begin
                case (state)
                    IDLE: begin
                        op  <= rx_op;
                        a16 <= spi_rx[A16_BIT];
                    end
                    ADDR_HI: hi          <= spi_rx;
                    ADDR_LO: bus_addr    <= ADDR_WIDTH'({a16, hi, spi_rx});
                    DATA:    bus_wr_data <= spi_rx;
                    default: ;
                endcase
            end
            if (state == ACCESS && bus_done) begin
                bus_addr <= bus_addr + ADDR_WIDTH'(1);
                if (is_read)
                    spi_tx <= bus_rd_data;
            end
            overrun <= reselect ? 1'b0 : (byte_strobe && state == ACCESS) ? 1'b1 : overrun;
        end
    end

endmodule

// File: doc/spi_cmd.md
Name: spi_cmd

Overview:
- Consumes bytes from the SCLK-domain SPI byte shifter (rx, valid, cs_n) and resynchronises them into the system clock domain.
- Decodes framed command packets into single-cycle-issued memory bus reads and writes, and returns read data to the shifter's tx byte for the next SPI byte.
- Sits between spi_byte and the system bus arbiter.

Parameters:
- ADDR_WIDTH, 17, bus address width; the A16 bit is carried in the command byte.
- SYNC_STAGES, 2, flop count in each CDC synchroniser (minimum 2).

Ports:
- clk  input  1  system clock; all state is clocked on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- spi_cs_n  input  1  SPI chip select, asynchronous to clk; low means selected.
- spi_rx  input  8  byte from spi_byte; stable while spi_valid is high.
- spi_valid  input  1  spi_byte valid, SCLK domain.
- spi_tx  output  8  byte returned to spi_byte for the next transfer.
- bus_addr  output  ADDR_WIDTH  current access address.
- bus_wr_data  output  8  write data.
- bus_rd_data  input  8  read data, sampled when bus_done is high.
- bus_rd_strobe  output  1  read request; held until bus_done.
- bus_wr_strobe  output  1  write request; held until bus_done.
- bus_done  input  1  access complete, one clk pulse.
- overrun  output  1  sticky flag: a byte arrived while an access was pending.

Behaviour:
- Reset values: every output 0; state IDLE; addr 0.
- CDC:
  - spi_valid and spi_cs_n each pass through a SYNC_STAGES synchroniser.
  - A rising edge of synced valid produces byte_strobe, and spi_rx is captured on that cycle.
  - Latency from spi_valid rising to capture is SYNC_STAGES+1 clk.
  - SPI is constrained so that valid stays high for at least SYNC_STAGES+2 clk; spi_rx is stable throughout.
- Command byte (first byte after select, or first byte after a completed packet):
  - bits[7:6] opcode: 00 WRITE_AT, 01 READ_AT, 10 WRITE_NEXT, 11 READ_NEXT.
  - bit[0] is A16; bits[5:1] are ignored.
- Packets:
  - WRITE_AT: cmd, addr_hi, addr_lo, data.
  - READ_AT: cmd, addr_hi, addr_lo.
  - WRITE_NEXT: cmd, data.
  - READ_NEXT: cmd.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA, ACCESS.
  - IDLE, on byte: latch opcode and A16.
    - *_AT goes to ADDR_HI.
    - WRITE_NEXT goes to DATA.
    - READ_NEXT goes to ACCESS.
  - ADDR_HI, on byte: go to ADDR_LO.
  - ADDR_LO, on byte: load addr = {A16, hi, lo}. READ_AT goes to ACCESS; WRITE_AT goes to DATA.
  - DATA, on byte: load bus_wr_data and go to ACCESS.
  - ACCESS:
    - The strobe is asserted on the first clk in ACCESS and held until bus_done.
    - On bus_done: deassert the strobe; for reads, spi_tx <= bus_rd_data; addr <= addr+1; go to IDLE.
- Address increment wraps from 1FFFF to 00000. The *_NEXT commands use the post-increment addr.
- bus_addr always reflects addr and is stable throughout ACCESS.
- Byte arriving during ACCESS: the byte is dropped, overrun is set, and the FSM is unaffected.
- spi_tx holds its value until the next read completes. It is not cleared by cs_n.
- Synced cs_n high (deselect):
  - In any state except ACCESS, the FSM goes to IDLE immediately and the partial packet is discarded.
  - In ACCESS, the access completes normally, then the FSM goes to IDLE.
  - overrun is cleared on the cs_n falling edge (reselect).
- bus_done outside ACCESS is ignored.
- Simultaneous byte_strobe and bus_done in ACCESS: the access completes, the byte is dropped, and overrun is set.
- Reset mid-access: strobes drop asynchronously and everything returns to reset values.

Decomposition:
- spi_cmd_pkg contains:
  - opcode_t enum (WRITE_AT, READ_AT, WRITE_NEXT, READ_NEXT);
  - state_t enum;
  - OPCODE_MSB/LSB and A16_BIT localparams.
- Sub-module sync: a parameterised SYNC_STAGES bit synchroniser with asynchronous reset. It is instantiated twice, once for valid and once for cs_n. The reset value for the cs_n instance is 1.

Test Plan:
- WRITE_AT 0x01 0x80 0x00 0x5A:
  - bus_wr_strobe rises with bus_addr=0x18000 and bus_wr_data=0x5A.
  - It holds until bus_done, then drops; addr becomes 0x18001.
- READ_AT 0x40 0xE8 0x10, with bus returning 0xC3:
  - bus_rd_strobe is issued at 0x0E810.
  - spi_tx becomes 0xC3 the cycle after bus_done; addr becomes 0x0E811.
- Wrap case, WRITE_AT to 0x1FFFF followed by WRITE_NEXT 0x80 0x11:
  - The second write goes to 0x00000 with data 0x11.
- Deselect after the 2 bytes 0x00 0x12:
  - No strobe is issued.
  - After reselect, READ_NEXT (0xC0) reads the pre-existing addr, proving the partial packet was discarded.
- Byte sent while bus_done is withheld for 200 clk:
  - overrun becomes 1 and the FSM completes the original access.
  - overrun clears on the next cs_n falling edge.
- Reset asserted while bus_wr_strobe is high:
  - All outputs are 0 within the same timestep.
  - A following READ_AT 0x40 0x00 0x00 works normally.
